// File: rtl/pkt_serializer_if.sv
// Packet-in / bits-out bundle for pkt_serializer.
// master = scheduler plus downstream stage (testbench side), slave = the serializer.
interface pkt_serializer_if #(
    parameter int MAX_BYTES = 8
);
    localparam int NBW = $clog2(MAX_BYTES + 1);

    logic                   pktready;
    logic                   pause;
    logic [3:0]             pid;
    logic [6:0]             addr;
    logic [3:0]             endp;
    logic [8*MAX_BYTES-1:0] data;
    logic [NBW-1:0]         nbytes;
    logic                   outb;
    logic                   sending;
    logic                   gotpkt;
    logic                   pktdone;

    modport master (
        output pktready, pause, pid, addr, endp, data, nbytes,
        input  outb, sending, gotpkt, pktdone
    );

    modport slave (
        input  pktready, pause, pid, addr, endp, data, nbytes,
        output outb, sending, gotpkt, pktdone
    );
endinterface

// File: rtl/pkt_serializer.sv
// Serial packet encoder: PID, token and variable-length data fields sent LSB-first.
// Define PKT_SERIALIZER_CRC_EN to append CRC5 to tokens and CRC16 to data packets.
module pkt_serializer #(
    parameter int MAX_BYTES = 8
) (
    input  logic            clk,
    input  logic            rst_L,
    pkt_serializer_if.slave bus
);
    localparam int DW  = 8 * MAX_BYTES;
    localparam int NBW = $clog2(MAX_BYTES + 1);
    localparam int CW  = $clog2(DW + 17);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND_PID,
        SEND_ADDR,
        SEND_ENDP,
        SEND_DATA
`ifdef PKT_SERIALIZER_CRC_EN
        ,
        SEND_CRC5,
        SEND_CRC16
`endif
    } state_t;

    state_t         state;
    state_t         next_field;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  last_idx;
    logic [CW-1:0]  data_bits;
    logic [3:0]     pid_q;
    logic [7:0]     pid_sr;
    logic [6:0]     addr_sr;
    logic [3:0]     endp_sr;
    logic [DW-1:0]  data_sr;
    logic [NBW-1:0] nbytes_q;
    logic           out_bit;
    logic           is_token;
    logic           is_data;
    logic           in_send;
    logic           consume;
    logic           field_last;

`ifdef PKT_SERIALIZER_CRC_EN
    logic [4:0]  crc5;
    logic [15:0] crc16;

    // Bit-serial update, register MSB aligned with the highest polynomial term.
    function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
        return {c[3:0], 1'b0} ^ ({5{c[4] ^ b}} & 5'h05);
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ({16{c[15] ^ b}} & 16'h8005);
    endfunction
`endif

    assign is_token   = (pid_q == 4'b0001) || (pid_q == 4'b1001);
    assign is_data    = (pid_q == 4'b0011) || (pid_q == 4'b1011);
    assign data_bits  = CW'(nbytes_q) << 3;
    assign in_send    = (state != IDLE) && (state != LOAD);
    assign consume    = in_send && !bus.pause;
    assign field_last = (cnt == last_idx);

    // Per-field bit source, final bit index and successor state.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        out_bit    = 1'b0;
        last_idx   = '0;
        next_field = IDLE;
        case (state)
            SEND_PID: begin
                out_bit  = pid_sr[0];
                last_idx = CW'(7);
                if (is_token) begin
                    next_field = SEND_ADDR;
                end else if (is_data && (nbytes_q != '0)) begin
                    next_field = SEND_DATA;
                end else if (is_data) begin
`ifdef PKT_SERIALIZER_CRC_EN
                    next_field = SEND_CRC16;
`else
                    next_field = IDLE;
`endif
                end
            end
            SEND_ADDR: begin
                out_bit    = addr_sr[0];
                last_idx   = CW'(6);
                next_field = SEND_ENDP;
            end
            SEND_ENDP: begin
                out_bit  = endp_sr[0];
                last_idx = CW'(3);
`ifdef PKT_SERIALIZER_CRC_EN
                next_field = SEND_CRC5;
`endif
            end
            SEND_DATA: begin
                out_bit  = data_sr[0];
                last_idx = data_bits - CW'(1);
`ifdef PKT_SERIALIZER_CRC_EN
                next_field = SEND_CRC16;
`endif
            end
`ifdef PKT_SERIALIZER_CRC_EN
            // The CRC field is the complemented remainder, MSB first.
            SEND_CRC5: begin
                out_bit  = ~crc5[4];
                last_idx = CW'(4);
            end
            SEND_CRC16: begin
                out_bit  = ~crc16[15];
                last_idx = CW'(15);
            end
`endif
            default: ;
        endcase
    end

    assign bus.outb    = in_send & out_bit;
    assign bus.sending = in_send;
    assign bus.gotpkt  = (state == LOAD);
    assign bus.pktdone = consume && field_last && (next_field == IDLE);

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state    <= IDLE;
            cnt      <= '0;
            pid_q    <= '0;
            pid_sr   <= '0;
            addr_sr  <= '0;
            endp_sr  <= '0;
            // NOTE: the payload is an ordinary flop register rather than a RAM, so it is reset too.
            data_sr  <= '0;
            nbytes_q <= '0;
`ifdef PKT_SERIALIZER_CRC_EN
            crc5     <= '0;
            crc16    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.pktready) state <= LOAD;
                end
                LOAD: begin
                    pid_q    <= bus.pid;
                    pid_sr   <= {~bus.pid, bus.pid};
                    addr_sr  <= bus.addr;
                    endp_sr  <= bus.endp;
                    data_sr  <= bus.data;
                    nbytes_q <= (bus.nbytes > NBW'(MAX_BYTES)) ? NBW'(MAX_BYTES) : bus.nbytes;
                    cnt      <= '0;
`ifdef PKT_SERIALIZER_CRC_EN
                    crc5     <= '1;
                    crc16    <= '1;
`endif
                    state    <= SEND_PID;
                end
                default: begin
                    if (consume) begin
                        cnt <= field_last ? '0 : cnt + CW'(1);
                        if (field_last) state <= next_field;
                        case (state)
                            SEND_PID:  pid_sr <= pid_sr >> 1;
                            SEND_ADDR: begin
                                addr_sr <= addr_sr >> 1;
`ifdef PKT_SERIALIZER_CRC_EN
                                crc5    <= crc5_step(crc5, addr_sr[0]);
`endif
                            end
                            SEND_ENDP: begin
                                endp_sr <= endp_sr >> 1;
`ifdef PKT_SERIALIZER_CRC_EN
                                crc5    <= crc5_step(crc5, endp_sr[0]);
`endif
                            end
                            SEND_DATA: begin
                                data_sr <= data_sr >> 1;
`ifdef PKT_SERIALIZER_CRC_EN
                                crc16   <= crc16_step(crc16, data_sr[0]);
`endif
                            end
`ifdef PKT_SERIALIZER_CRC_EN
                            SEND_CRC5:  crc5  <= crc5 << 1;
                            SEND_CRC16: crc16 <= crc16 << 1;
`endif
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pkt_serializer.sv
// Scoreboard bench for pkt_serializer: a packet-level model queues the expected bit
// stream; a negedge monitor pops one bit per consumed cycle and compares.
module tb_pkt_serializer;
    localparam int MAX_BYTES = 8;
    localparam int DW        = 8 * MAX_BYTES;
    localparam int NBW       = $clog2(MAX_BYTES + 1);
`ifdef PKT_SERIALIZER_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_L = 1'b0;
    always #5 clk = ~clk;

    pkt_serializer_if #(.MAX_BYTES(MAX_BYTES)) bus ();
    pkt_serializer #(.MAX_BYTES(MAX_BYTES)) dut (.clk(clk), .rst_L(rst_L), .bus(bus));

    exp_t exp_q[$];
    int   gap_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_got = 0;
    int   pkt_bits = 0;
    int   sending_cycles = 0;
    int   last_pkt_cycles = 0;
    int   gap_cnt = 0;
    logic prev_got = 1'b0;
    logic prev_sending = 1'b0;
    logic rand_pause = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Remainder of the message bits (in transmit order) for a width-w generator.
    function automatic logic [15:0] crc_rem(input logic msg[$], input int w,
                                            input logic [15:0] poly, input logic [15:0] init);
        logic [15:0] r;
        logic [15:0] mask;
        logic        top;
        r    = init;
        mask = 16'((32'd1 << w) - 1);
        foreach (msg[i]) begin
            top = r[w-1] ^ msg[i];
            r   = ((r << 1) & mask) ^ (top ? poly : 16'h0000);
        end
        return r;
    endfunction

    task automatic push_model(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                              input logic [DW-1:0] d, input int nb);
        logic        bits[$];
        logic        msg[$];
        logic [15:0] r;
        exp_t        x;
        int          eff;
        eff = (nb > MAX_BYTES) ? MAX_BYTES : nb;
        for (int i = 0; i < 4; i++) bits.push_back(p[i]);
        for (int i = 0; i < 4; i++) bits.push_back(~p[i]);
        if (p[2:0] == 3'b001) begin
            for (int i = 0; i < 7; i++) msg.push_back(a[i]);
            for (int i = 0; i < 4; i++) msg.push_back(e[i]);
            foreach (msg[i]) bits.push_back(msg[i]);
            if (CRC_ON) begin
                r = crc_rem(msg, 5, 16'h0005, 16'h001F);
                for (int i = 4; i >= 0; i--) bits.push_back(~r[i]);
            end
        end else if (p[2:0] == 3'b011) begin
            for (int k = 0; k < eff; k++)
                for (int i = 0; i < 8; i++) msg.push_back(d[8*k+i]);
            foreach (msg[i]) bits.push_back(msg[i]);
            if (CRC_ON) begin
                r = crc_rem(msg, 16, 16'h8005, 16'hFFFF);
                for (int i = 15; i >= 0; i--) bits.push_back(~r[i]);
            end
        end
        for (int i = 0; i < bits.size(); i++) begin
            x.b    = bits[i];
            x.last = (i == bits.size() - 1);
            exp_q.push_back(x);
        end
    endtask

    // Monitor: compares on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t x;
        if (!rst_L) begin
            pkt_bits       = 0;
            sending_cycles = 0;
            gap_cnt        = 0;
            prev_got       = 1'b0;
            prev_sending   = 1'b0;
        end else begin
            if (bus.gotpkt) begin
                n_got++;
                check("gotpkt_single_cycle", prev_got, 1'b0);
            end
            prev_got = bus.gotpkt;
            if (!bus.sending) begin
                check("idle_outb_pktdone", {bus.outb, bus.pktdone}, 2'b00);
                gap_cnt++;
            end else begin
                if (!prev_sending) gap_q.push_back(gap_cnt);
                sending_cycles++;
                check("bit_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    check("outb", bus.outb, exp_q[0].b);
                    if (!bus.pause) begin
                        x = exp_q.pop_front();
                        check("pktdone", bus.pktdone, x.last);
                        pkt_bits++;
                        if (x.last) begin
                            last_pkt_cycles = sending_cycles;
                            sending_cycles  = 0;
                            pkt_bits        = 0;
                            gap_cnt         = 0;
                        end
                    end else begin
                        check("pktdone_paused", bus.pktdone, 1'b0);
                    end
                end
            end
            prev_sending = bus.sending;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_pause) bus.pause = ($urandom_range(0, 3) == 0);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic wait_got();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.gotpkt) begin
                seen = 1'b1;
                break;
            end
        end
        check("gotpkt_seen", seen, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.sending) begin
                done = 1'b1;
                break;
            end
        end
        check("drain", done, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                         input logic [DW-1:0] d, input int nb);
        bus.pid    = p;
        bus.addr   = a;
        bus.endp   = e;
        bus.data   = d;
        bus.nbytes = NBW'(nb);
    endtask

    task automatic send(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                        input logic [DW-1:0] d, input int nb);
        push_model(p, a, e, d, nb);
        drive(p, a, e, d, nb);
        bus.pktready = 1'b1;
        wait_got();
        bus.pktready = 1'b0;
    endtask

    initial begin
        int          got0;
        logic [3:0]  rp;
        logic [DW-1:0] rd;
        bus.pktready = 1'b0;
        bus.pause    = 1'b0;
        drive(4'h0, 7'h00, 4'h0, '0, 0);

        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.outb, bus.sending, bus.gotpkt, bus.pktdone}, 4'b0000);
        @(posedge clk);
        #1;
        rst_L = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        send(4'b0010, 7'h00, 4'h0, '0, 0);
        wait_drain();
        check("ack_len", last_pkt_cycles, 8);

        send(4'b0001, 7'h15, 4'hE, '0, 0);
        wait_drain();
        check("token_len", last_pkt_cycles, CRC_ON ? 24 : 19);

        send(4'b1011, 7'h00, 4'h0, '0, 0);
        wait_drain();
        check("data1_empty_len", last_pkt_cycles, CRC_ON ? 24 : 8);

        // Pause held for three cycles from the cycle presenting bit 10.
        send(4'b0011, 7'h00, 4'h0, 64'hA5, 1);
        repeat (10) @(posedge clk);
        #1;
        bus.pause = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.pause = 1'b0;
        wait_drain();
        check("paused_len", last_pkt_cycles, CRC_ON ? 35 : 19);

        // Clamped payload, pktready held for three back-to-back packets.
        gap_q.delete();
        got0 = n_got;
        rd   = {$urandom, $urandom};
        push_model(4'b0011, 7'h00, 4'h0, rd, 9);
        drive(4'b0011, 7'h00, 4'h0, rd, 9);
        bus.pktready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_got();
            if (k < 2) begin
                rd = {$urandom, $urandom};
                push_model(4'b0011, 7'h00, 4'h0, rd, 9);
                drive(4'b0011, 7'h00, 4'h0, rd, 9);
            end else begin
                bus.pktready = 1'b0;
            end
        end
        wait_drain();
        check("b2b_len", last_pkt_cycles, CRC_ON ? 88 : 72);
        check("b2b_gotpkt_count", n_got - got0, 3);
        check("b2b_gap_entries", gap_q.size(), 3);
        if (gap_q.size() == 3) begin
            check("b2b_gap1", gap_q[1], 2);
            check("b2b_gap2", gap_q[2], 2);
        end

        // Reset while data bit 20 (packet bit 28) is on the line.
        send(4'b0011, 7'h00, 4'h0, {$urandom, $urandom}, 4);
        for (int i = 0; i < 100; i++) begin
            if (pkt_bits == 28 && bus.sending) break;
            @(posedge clk);
            #1;
        end
        check("reset_point_reached", pkt_bits, 28);
        rst_L = 1'b0;
        #1;
        check("midpkt_reset_outputs", {bus.outb, bus.sending, bus.gotpkt, bus.pktdone}, 4'b0000);
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_L = 1'b1;
        @(posedge clk);
        #1;
        send(4'b0010, 7'h00, 4'h0, '0, 0);
        wait_drain();
        check("post_reset_ack_len", last_pkt_cycles, 8);

        // Randomized packets, with random downstream stalls in the second half.
        for (int n = 0; n < 40; n++) begin
            rand_pause = (n >= 20);
            case ($urandom_range(0, 6))
                0: rp = 4'b0001;
                1: rp = 4'b1001;
                2: rp = 4'b0011;
                3: rp = 4'b1011;
                4: rp = 4'b0010;
                5: rp = 4'b1010;
                default: rp = 4'($urandom);
            endcase
            send(rp, 7'($urandom), 4'($urandom), {$urandom, $urandom}, $urandom_range(0, 9));
            wait_drain();
        end
        rand_pause = 1'b0;
        @(posedge clk);
        #1;
        bus.pause = 1'b0;
        repeat (3) @(posedge clk);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pkt_serializer.md
# pkt_serializer

Parametrised serial packet encoder and next generation of the bitstream encoder. Accepts one parallel packet at a time: PID, token address and endpoint, or a variable-length data payload. Emits the fields LSB-first on a single serial line. Adds variable payload length, DATA1 support and optional CRC5/CRC16 generation. Sits between the packet scheduler and the NRZI/bit-stuffing stage, which throttles it through `pause`.

## Interface
- `MAX_BYTES`, default 8: maximum data payload in bytes (≥1).
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_L` in 1: asynchronous, active-low reset.
- `pktready` in 1: packet on the inputs is valid; sampled only in IDLE.
- `pause` in 1: downstream stall; hold the current bit.
- `pid` in 4: packet ID.
- `addr` in 7: token address.
- `endp` in 4: token endpoint.
- `data` in 8*MAX_BYTES: payload; byte k is at [8k+7:8k], and byte 0 is sent first.
- `nbytes` in $clog2(MAX_BYTES+1): payload length in bytes; values above MAX_BYTES clamp to MAX_BYTES.
- `outb` out 1: serial bit.
- `sending` out 1: `outb` is a valid packet bit.
- `gotpkt` out 1: one-cycle pulse; inputs captured, upstream may change them.
- `pktdone` out 1: one-cycle pulse; the final bit of the packet is consumed.

## Operation
- **States:** IDLE, LOAD, SEND_PID, SEND_ADDR, SEND_ENDP, SEND_DATA, SEND_CRC5, SEND_CRC16.
- **IDLE → LOAD** when `pktready`=1. LOAD captures all inputs (`nbytes` clamped), asserts `gotpkt`, clears the bit counter and presets both CRCs to all ones. LOAD → SEND_PID unconditionally.
- **PID field:** 8 bits, {~pid, pid}, with pid[0] sent first.
- **Sequence by captured PID:**
  - OUT (0001) / IN (1001): PID → ADDR (7) → ENDP (4) → CRC5 (5) → IDLE.
  - DATA0 (0011) / DATA1 (1011): PID → DATA (8·nbytes) → CRC16 (16) → IDLE. With nbytes=0 the DATA state is skipped.
  - All other PIDs (ACK 0010, NAK 1010, undefined): PID only → IDLE.
- **CRC5:**
  - Polynomial x^5+x^2+1, init 5'h1F.
  - Updated serially with each ADDR and ENDP bit as it is consumed.
  - The field is the bitwise complement of the remainder, with the remainder MSB sent first.
- **CRC16:**
  - Polynomial x^16+x^15+x^2+1, init 16'hFFFF.
  - Updated with each DATA bit; same complement and ordering rule as CRC5.
- **Pause:**
  - A bit is consumed only in a cycle with `pause`=0. That cycle shifts the field register, advances the counter and updates the CRC.
  - With `pause`=1, `outb` holds the current bit and `sending` stays 1.
- **Field transition:** when the last bit of a field is consumed, move to the next state and clear the counter.
- **`pktready`** is ignored in every state except IDLE.

## Timing
- **Reset values:** state IDLE; `outb`, `sending`, `gotpkt` and `pktdone` are all 0. Reset asserted mid-packet aborts immediately (asynchronous) and discards the packet.
- **IDLE and LOAD:** `outb`=0, `sending`=0.
- **Latency:** `pktready` high in IDLE cycle N → `gotpkt` in N+1 → first bit on `outb` in N+2.
- **Bits per packet:** handshake 8; token 24; data 24+8·nbytes (CRC_EN defined).
- **`pktdone`:** asserted combinationally in the cycle the last bit is presented with `pause`=0. The following cycle is IDLE.
- **Back-to-back:** `pktready` held high gives exactly two non-sending cycles between packets (IDLE, LOAD).
- **Output decode:** `outb`, `sending` and `gotpkt` are decoded from state and registered datapath only. `pktdone` additionally depends on `pause`.

## Configuration
- `PKT_SERIALIZER_CRC_EN` defined: CRC5/CRC16 logic and states are present, as described above.
- Not defined:
  - CRC states, CRC registers and their logic are removed.
  - Tokens end after ENDP (19 bits); data packets end after DATA (8+8·nbytes bits).
  - DATA with nbytes=0 is 8 bits.

## Test plan
- **ACK:** pid=4'b0010, `pause`=0 → `gotpkt` one cycle, then `outb`=0,1,0,0,1,0,1,1 over 8 cycles with `sending`=1, `pktdone` on the 8th bit, then IDLE.
- **OUT token:** addr=7'h15, endp=4'hE → 24 sending cycles. PID bits 1,0,0,0,0,1,1,1; addr bits 1,0,1,0,1,0,0; endp bits 0,1,1,1. The 5 CRC bits match the bit-serial reference model.
- **DATA1, nbytes=0:** 24 sending cycles: PID bits 1,1,0,1,0,0,1,0, then sixteen 0 bits (complement of 16'hFFFF).
- **DATA0 with pause:** nbytes=1, data=8'hA5, `pause` high 3 cycles starting at bit 10 → `outb` holds bit 10 for 4 cycles, 35 total sending cycles. CRC16 bits are identical to the unpaused run.
- **Clamp and back-to-back:** MAX_BYTES=8, nbytes=9, `pktready` held high → 88-bit packets separated by exactly 2 non-sending cycles, one `gotpkt` per packet.
- **Reset mid-packet:** `rst_L` low during data bit 20 → all outputs 0 in the same cycle. After release, the next ACK is sent intact.
